// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO and launch controller that sits directly in front of a UART
//   transmitter. The host pushes bytes on clk. The block presents the head
//   byte on tx_data and raises tx_start. It keeps tx_start high until the
//   transmitter's busy flag is seen (after synchronisation), so a launch
//   request cannot be missed by the slower transmitter clock domain.
//
// Ports
//   clk, rstn           system clock (rising edge), async active-low reset
//   wr_en, wr_data      host write strobe and byte, one byte per cycle
//   clr_err             clears the sticky overflow and start_timeout flags
//   tx_busy             transmitter busy, asynchronous to clk
//   tx_start, tx_data   level launch request and the byte it carries
//   full, empty, level  FIFO status; level counts the byte being launched
//   overflow            sticky: a write was attempted while full
//   start_timeout       sticky: busy did not rise within TIMEOUT cycles
`timescale 1ns/1ps

module uart_tx_feeder #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_err,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              start_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_e;

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  logic rst_meta_q, rst_n_q;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic                 busy_meta_q, busy_s_q;
  logic [7:0]           mem_q [DEPTH];
  logic [ADDR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]      level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q, timeout_d;
  state_e               state_q, state_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 full_w, empty_w, push, pop, timeout_evt;

  assign full_w  = (level_q == LVL_FULL);
  assign empty_w = (level_q == '0);
  // A pop in the same cycle does not make room for a write while full.
  assign push    = wr_en && !full_w;

  // Launch FSM: registered outputs computed here, captured below.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    tmr_d       = tmr_q;
    pop         = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A stale busy from a previous frame holds off the next launch.
        if (!empty_w && !busy_s_q) begin
          state_d    = S_START;
          tx_data_d  = mem_q[rptr_q];
          tx_start_d = 1'b1;
          tmr_d      = '0;
        end
      end
      S_START: begin
        if (busy_s_q) begin
          // Transmitter has taken the byte: only now is it removed.
          state_d    = S_BUSY;
          tx_start_d = 1'b0;
          pop        = 1'b1;
        end else if (tmr_q == TMR_MAX) begin
          // Give up on this attempt; the byte stays queued and is retried.
          state_d     = S_IDLE;
          tx_start_d  = 1'b0;
          timeout_evt = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_BUSY: begin
        if (!busy_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        tx_start_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wptr_d     = push ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + ADDR_W'(1) : rptr_q;
    level_d    = level_q;
    if (push && !pop)      level_d = level_q + (ADDR_W + 1)'(1);
    else if (pop && !push) level_d = level_q - (ADDR_W + 1)'(1);
    // A new event in the clearing cycle wins over clr_err.
    overflow_d = (overflow_q && !clr_err) || (wr_en && full_w);
    timeout_d  = (timeout_q  && !clr_err) || timeout_evt;
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      state_q     <= S_IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tmr_q       <= '0;
    end else begin
      busy_meta_q <= tx_busy;
      busy_s_q    <= busy_meta_q;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      tmr_q       <= tmr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so clearing the data would only cost area and timing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign start_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder. A simple transmitter model raises busy
//   4 clocks after it sees tx_start and holds it for 40 clocks; tests can also
//   force busy high directly. Inputs change and outputs are sampled on the
//   falling clock edge.
`timescale 1ns/1ps

module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 256;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             clr_err = 1'b0;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             full, empty, overflow, start_timeout;
  logic [ADDR_W:0]  level;

  logic model_en = 1'b0;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  assign tx_busy = model_busy | force_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rise_cnt = 0;
  int stab_err = 0;
  logic [7:0] sent_q [$];

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .clr_err(clr_err), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .start_timeout(start_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model: accepts the byte on tx_start and runs one frame.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && tx_start) begin
        sent_q.push_back(tx_data);
        repeat (4) @(negedge clk);
        model_busy = 1'b1;
        repeat (40) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Count launch requests and watch that tx_data holds while tx_start is high.
  logic       prev_start = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (tx_start && prev_start && tx_data !== prev_data) stab_err++;
    if (tx_start && !prev_start) rise_cnt++;
    prev_start = tx_start;
    prev_data  = tx_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_start(input logic v, input int max, input string name);
    for (int i = 0; i < max && tx_start !== v; i++) @(negedge clk);
    n_tests++;
    if (tx_start !== v) begin
      n_fail++;
      $display("FAIL %s: tx_start=%b after %0d cycles, expected %b", name, tx_start, max, v);
    end
  endtask

  task automatic wait_drain(input int max, input string name);
    for (int i = 0; i < max && !(empty && !tx_start && !tx_busy); i++) @(negedge clk);
    n_tests++;
    if (!(empty && !tx_start && !tx_busy)) begin
      n_fail++;
      $display("FAIL %s: not drained, level=%0d tx_start=%b busy=%b", name, level, tx_start, tx_busy);
    end
    repeat (4) @(negedge clk);
  endtask

  localparam logic [16:0] RST_VEC = {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({tx_start, tx_data, level, empty, full, overflow, start_timeout} !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h",
               {tx_start, tx_data, level, empty, full, overflow, start_timeout}, RST_VEC);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h01); push(8'h02); push(8'h03);
    wait_start(1'b1, 5, "reset_pre_start");
    n_tests++;
    if (level !== 5'd3) begin
      n_fail++; $display("FAIL reset_pre_level: got %0d expected 3", level);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({tx_start, tx_data, level, empty, full, overflow, start_timeout} !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_start: got %h expected %h",
               {tx_start, tx_data, level, empty, full, overflow, start_timeout}, RST_VEC);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_two_bytes();
    int base, r0;
    base = sent_q.size();
    r0 = rise_cnt;
    model_en = 1'b1;
    push(8'hA5);
    n_tests++;
    if ({tx_start, level} !== {1'b0, 5'd1}) begin
      n_fail++; $display("FAIL latency_n1: start/level got %b/%0d expected 0/1", tx_start, level);
    end
    push(8'h3C);
    n_tests++;
    if ({tx_start, tx_data, level} !== {1'b1, 8'hA5, 5'd2}) begin
      n_fail++;
      $display("FAIL latency_n2: start/data/level got %b/%h/%0d expected 1/a5/2", tx_start, tx_data, level);
    end
    wait_start(1'b0, 20, "first_commit");
    n_tests++;
    if (level !== 5'd1) begin
      n_fail++; $display("FAIL level_after_first: got %0d expected 1", level);
    end
    wait_start(1'b1, 60, "second_launch");
    n_tests++;
    if (tx_data !== 8'h3C) begin
      n_fail++; $display("FAIL second_data: got %h expected 3c", tx_data);
    end
    wait_start(1'b0, 20, "second_commit");
    n_tests++;
    if (level !== 5'd0) begin
      n_fail++; $display("FAIL level_after_second: got %0d expected 0", level);
    end
    wait_drain(100, "two_bytes_drain");
    n_tests++;
    if (sent_q.size() - base !== 2 || rise_cnt - r0 !== 2 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL two_bytes_count: sent=%0d rises=%0d empty=%b expected 2/2/1",
               sent_q.size() - base, rise_cnt - r0, empty);
    end else begin
      n_tests++;
      if (sent_q[base] !== 8'hA5 || sent_q[base+1] !== 8'h3C) begin
        n_fail++;
        $display("FAIL two_bytes_order: got %h %h expected a5 3c", sent_q[base], sent_q[base+1]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    int base;
    base = sent_q.size();
    model_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    n_tests++;
    if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_16: full/level/ovf got %b/%0d/%b expected 1/16/0", full, level, overflow);
    end
    push(8'h10);
    n_tests++;
    if ({full, level, overflow} !== {1'b1, 5'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_17: full/level/ovf got %b/%0d/%b expected 1/16/1", full, level, overflow);
    end
    pulse_clr();
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
    model_en = 1'b1;
    wait_drain(1200, "fill_drain");
    n_tests++;
    if (sent_q.size() - base !== 16) begin
      n_fail++; $display("FAIL fill_count: got %0d expected 16", sent_q.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (sent_q[base+i] !== 8'(i)) begin
          n_fail++; $display("FAIL fill_order[%0d]: got %h expected %h", i, sent_q[base+i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    model_en = 1'b0;
    n_tests++;
    if (start_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pre: got %b expected 0", start_timeout);
    end
    push(8'h77);
    wait_start(1'b1, 5, "timeout_launch");
    cnt = 0;
    while (tx_start === 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    n_tests++;
    if (cnt !== TIMEOUT || start_timeout !== 1'b1 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL timeout_abort: cycles/flag/level got %0d/%b/%0d expected %0d/1/1",
               cnt, start_timeout, level, TIMEOUT);
    end
    wait_start(1'b1, 5, "timeout_retry");
    n_tests++;
    if (tx_data !== 8'h77) begin
      n_fail++; $display("FAIL timeout_retry_data: got %h expected 77", tx_data);
    end
    pulse_clr();
    n_tests++;
    if (start_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %b expected 0", start_timeout);
    end
    model_en = 1'b1;
    wait_drain(200, "timeout_drain");
  endtask

  task automatic test_commit_write();
    model_en = 1'b0;
    push(8'h11);
    wait_start(1'b1, 5, "commit_launch");
    // busy_s rises two edges after busy; the commit is on the third edge.
    force_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    n_tests++;
    if ({tx_start, level} !== {1'b0, 5'd1}) begin
      n_fail++;
      $display("FAIL commit_same_cycle: start/level got %b/%0d expected 0/1", tx_start, level);
    end
    force_busy = 1'b0;
    wait_start(1'b1, 10, "commit_next_launch");
    n_tests++;
    if (tx_data !== 8'h22) begin
      n_fail++; $display("FAIL commit_next_data: got %h expected 22", tx_data);
    end
    force_busy = 1'b1;
    wait_start(1'b0, 10, "commit_next_commit");
    n_tests++;
    if (level !== 5'd0) begin
      n_fail++; $display("FAIL commit_final_level: got %0d expected 0", level);
    end
    force_busy = 1'b0;
    wait_drain(20, "commit_drain");
  endtask

  task automatic test_stale_busy();
    logic seen;
    model_en = 1'b0;
    force_busy = 1'b1;
    repeat (4) @(negedge clk);
    push(8'h5A);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    n_tests++;
    if ({seen, level} !== {1'b0, 5'd1}) begin
      n_fail++; $display("FAIL stale_hold: start_seen/level got %b/%0d expected 0/1", seen, level);
    end
    force_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (tx_start !== 1'b0) begin
      n_fail++; $display("FAIL stale_sync_delay: got %b expected 0", tx_start);
    end
    @(negedge clk);
    n_tests++;
    if ({tx_start, tx_data} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL stale_release: start/data got %b/%h expected 1/5a", tx_start, tx_data);
    end
    model_en = 1'b1;
    wait_drain(100, "stale_drain");
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_fill_overflow();
    test_timeout();
    test_commit_write();
    test_stale_busy();
    n_tests++;
    if (stab_err !== 0) begin
      n_fail++; $display("FAIL tx_data_stable: %0d changes while tx_start high, expected 0", stab_err);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
